// File: rtl/axil_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axil_rr_arbiter: round-robin arbiter of N_REQ requesters onto one AXI-Lite   |
// | master, one transaction at a time. Optional macro ARB_GRANT_CNT_EN adds      |
// | per-requester saturating completion counters (grant_cnt).                    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module axil_rr_arbiter #(
  parameter int M_AXI_ADDR_WIDTH = 32,
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int N_REQ            = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [N_REQ-1:0]                     req_we,
  input  logic [N_REQ*M_AXI_ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*M_AXI_DATA_WIDTH-1:0]    req_wdata,
  output logic [N_REQ-1:0]                     req_done,
  output logic [M_AXI_DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                           rsp_resp,
  output logic                                 busy,
`ifdef ARB_GRANT_CNT_EN
  output logic [N_REQ*16-1:0]                  grant_cnt,
`endif
  output logic [M_AXI_ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic [2:0]                           m_axi_awprot,
  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [M_AXI_DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [M_AXI_DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  input  logic [1:0]                           m_axi_bresp,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  output logic [M_AXI_ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic [2:0]                           m_axi_arprot,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [M_AXI_DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                      r_state, w_next;
  logic [IW-1:0]               r_grant, r_last;
  logic                        r_we;
  logic [M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic                        r_aw_done, r_w_done;
  logic [M_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                  r_resp;

  logic                        w_gnt_vld;
  logic [IW-1:0]               w_gnt_idx;
  logic [IW-1:0]               w_cand;
  logic                        w_aw_hs, w_w_hs;

  // Walk offsets from farthest to nearest so the closest valid requester after r_last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_last) + k) % N_REQ);
      if (req_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_w_hs  = m_axi_wvalid  && m_axi_wready;

  always_comb begin
    w_next        = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    req_done      = '0;
    busy          = (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_gnt_vld) w_next = req_we[w_gnt_idx] ? WR_ADDR : RD_ADDR;
      WR_ADDR: begin
        m_axi_awvalid = !r_aw_done;
        m_axi_wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) w_next = DONE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_next = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) w_next = DONE;
      end
      DONE: begin
        req_done[r_grant] = 1'b1;
        w_next            = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= IW'(N_REQ - 1);
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_grant   <= w_gnt_idx;
          r_we      <= req_we[w_gnt_idx];
          r_addr    <= req_addr[int'(w_gnt_idx)*M_AXI_ADDR_WIDTH +: M_AXI_ADDR_WIDTH];
          r_wdata   <= req_wdata[int'(w_gnt_idx)*M_AXI_DATA_WIDTH +: M_AXI_DATA_WIDTH];
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        WR_ADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        WR_RESP: if (m_axi_bvalid) begin
          r_resp  <= m_axi_bresp;
          r_rdata <= '0;
        end
        RD_DATA: if (m_axi_rvalid) begin
          r_resp  <= m_axi_rresp;
          r_rdata <= m_axi_rdata;
        end
        DONE:    r_last <= r_grant;
        default: ;
      endcase
    end
  end

  assign rsp_rdata    = r_rdata;
  assign rsp_resp     = r_resp;
  assign m_axi_awaddr = r_addr;
  assign m_axi_araddr = r_addr;
  assign m_axi_wdata  = r_wdata;
  assign m_axi_wstrb  = '1;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

`ifdef ARB_GRANT_CNT_EN
  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
      logic [15:0] r_cnt;
      always_ff @(posedge i_clk) begin
        if (i_rst)                              r_cnt <= '0;
        else if (req_done[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
      assign grant_cnt[g*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_axil_rr_arbiter: directed bench with a behavioural AXI-Lite slave.        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_axil_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;
`ifdef ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;

  axil_rr_arbiter #(.M_AXI_ADDR_WIDTH(AW), .M_AXI_DATA_WIDTH(DW), .N_REQ(N)) dut (
    .i_clk(clk), .i_rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
`ifdef ARB_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  // Behavioural slave: AW/AR always ready, W ready after w_delay cycles, R after r_wait cycles.
  int          w_delay = 0, r_wait = 0;
  logic [1:0]  bresp_k = 2'b00;
  logic [DW-1:0] rdata_k = '0;
  int          w_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0, bvalid_r = 1'b0;

  assign awready = 1'b1;
  assign arready = 1'b1;
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_k;
  assign rvalid  = r_pend && (r_cnt >= r_wait);
  assign rdata   = rdata_k;
  assign rresp   = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      w_cnt <= 0; r_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0; bvalid_r <= 1'b0;
    end else begin
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      else                   w_cnt <= 0;
      if (bvalid_r && bready) begin
        bvalid_r <= 1'b0; b_cnt <= b_cnt + 1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
        if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !bvalid_r)
          bvalid_r <= 1'b1;
      end
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
      end else if (rvalid && rready) r_pend <= 1'b0;
      else if (r_pend)               r_cnt  <= r_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // lat counts cycles inclusively, the grant cycle being cycle 1.
  task automatic wait_done(input int lat0, input int maxc, output int lat, output bit busy_all);
    lat = lat0;
    busy_all = busy;
    while (req_done == '0 && lat < maxc) begin
      tick();
      lat++;
      busy_all &= busy;
    end
    chk("done_seen", {63'd0, req_done != '0}, 64'd1);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ba;
    int  b0;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    tick(); tick(); tick();
    chk("rst_ctl", {58'd0, awvalid, wvalid, bready, arvalid, rready, busy}, 64'd0);
    chk("rst_done", {60'd0, req_done}, 64'd0);
    chk("rst_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
    rst = 1'b0;
    tick();

    // Single write, requester 0, zero-wait slave.
    req_valid = 4'b0001; req_we = 4'b0001;
    req_addr[0*AW +: AW] = 32'h10; req_wdata[0*DW +: DW] = 32'hDEADBEEF;
    chk("wr_grant_busy", {63'd0, busy}, 64'd0);
    tick();
    req_addr[0*AW +: AW] = 32'hBAD0; req_wdata[0*DW +: DW] = 32'h0;
    chk("wr_aw_w_together", {62'd0, awvalid, wvalid}, 64'd3);
    chk("wr_awaddr", {32'd0, awaddr}, 64'h10);
    chk("wr_wdata", {32'd0, wdata}, 64'hDEADBEEF);
    chk("wr_wstrb_prot", {54'd0, wstrb, awprot, arprot}, {54'd0, 4'hF, 6'd0});
    tick();
    chk("wr_resp_phase", {60'd0, awvalid, wvalid, bready, req_done != '0}, 64'b0010);
    tick();
    chk("wr_done_at_cycle4", {60'd0, req_done}, 64'b0001);
    chk("wr_resp", {62'd0, rsp_resp}, 64'd0);
    req_valid = '0;
    tick();
    chk("wr_pulse_1cyc", {59'd0, busy, req_done}, 64'd0);

    // Single read, requester 2, three wait states on rvalid.
    r_wait = 3; rdata_k = 32'h12345678;
    req_valid = 4'b0100; req_we = 4'b0000; req_addr[2*AW +: AW] = 32'h20;
    tick();
    chk("rd_ar", {31'd0, arvalid, araddr}, {31'd0, 1'b1, 32'h20});
    wait_done(2, 30, lat, ba);
    chk("rd_done", {60'd0, req_done}, 64'b0100);
    chk("rd_rdata", {32'd0, rsp_rdata}, 64'h12345678);
    chk("rd_busy_throughout", {63'd0, ba}, 64'd1);
    chk("rd_latency", lat, 64'd7);
    req_valid = '0;
    tick();
    chk("rd_rdata_hold", {27'd0, busy, req_done, rsp_rdata}, {32'd0, 32'h12345678});

    // Split handshake with BRESP=SLVERR, requester 3; valid dropped after grant.
    w_delay = 2; bresp_k = 2'b10; b0 = b_cnt;
    req_valid = 4'b1000; req_we = 4'b1000;
    req_addr[3*AW +: AW] = 32'h30; req_wdata[3*DW +: DW] = 32'hCAFE0003;
    tick();
    req_valid = '0; req_addr[3*AW +: AW] = 32'h0;
    chk("sp_c1", {62'd0, awvalid, wvalid}, 64'b11);
    tick();
    chk("sp_c2_aw_drop", {62'd0, awvalid, wvalid}, 64'b01);
    tick();
    chk("sp_c3", {62'd0, awvalid, wvalid}, 64'b01);
    tick();
    chk("sp_c4_w_drop", {61'd0, awvalid, wvalid, bready}, 64'b001);
    wait_done(5, 30, lat, ba);
    chk("sp_done", {60'd0, req_done}, 64'b1000);
    chk("sp_bresp", {62'd0, rsp_resp}, 64'd2);
    chk("sp_rdata_zero_after_wr", {32'd0, rsp_rdata}, 64'd0);
    tick(); tick(); tick();
    chk("sp_one_b", b_cnt - b0, 64'd1);

    // Reset in RD_DATA, requester 1: abandoned without a completion.
    w_delay = 0; bresp_k = 2'b00; r_wait = 5;
    req_valid = 4'b0010; req_we = 4'b0000; req_addr[1*AW +: AW] = 32'h44;
    tick();
    chk("rs_ar_req1", {31'd0, arvalid, araddr}, {31'd0, 1'b1, 32'h44});
    tick();
    chk("rs_in_rd_data", {63'd0, rready}, 64'd1);
    rst = 1'b1;
    tick();
    chk("rs_ctl", {58'd0, awvalid, wvalid, bready, arvalid, rready, busy}, 64'd0);
    chk("rs_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
    chk("rs_no_done", {60'd0, req_done}, 64'd0);
    tick();
    chk("rs_no_done2", {60'd0, req_done}, 64'd0);

    // Fairness after reset: all four writers held, expect 0,1,2,3,0,1,2,3 back-to-back.
    r_wait = 0; b0 = b_cnt;
    rst = 1'b0;
    req_valid = 4'b1111; req_we = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_done(1, 20, lat, ba);
      chk($sformatf("fair_order_%0d", i), oh_idx(req_done), i % 4);
      chk($sformatf("fair_lat_%0d", i), lat, 64'd4);
      tick();
    end
    req_valid = '0;
    tick(); tick();
    chk("fair_b_count", b_cnt - b0, 64'd8);
`ifdef ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++) chk($sformatf("grant_cnt_%0d", i), grant_cnt[i*16 +: 16], 64'd2);
`endif
    chk("end_idle", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axil_rr_arbiter.md
AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

Interface
REQ-001 Parameters SHALL be: M_AXI_ADDR_WIDTH, default 32, AXI-Lite address width; M_AXI_DATA_WIDTH, default 32, AXI-Lite data width; N_REQ, default 4, number of requesters (2..8).
REQ-002 i_clk  in  1  single block clock; AXI ports are synchronous to it.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  N_REQ  per-requester transaction request, held until req_done.
REQ-005 req_we  in  N_REQ  1 = write, 0 = read.
REQ-006 req_addr  in  N_REQ*M_AXI_ADDR_WIDTH  flattened addresses, requester i at slice i.
REQ-007 req_wdata  in  N_REQ*M_AXI_DATA_WIDTH  flattened write data.
REQ-008 req_done  out  N_REQ  one-cycle completion pulse, one-hot.
REQ-009 rsp_rdata  out  M_AXI_DATA_WIDTH  read data, valid while any req_done bit is high.
REQ-010 rsp_resp  out  2  BRESP or RRESP of the completed transaction, valid with req_done.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 The AXI-Lite master SHALL provide m_axi_aw*, w*, b*, ar* and r* signals with the standard directions and widths. wstrb is tied all-ones; prot is tied 0.

Function
REQ-013 The FSM SHALL have the states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-014 IDLE: with any req_valid set, the block SHALL grant by round-robin, searching from the index after last_grant and wrapping N_REQ-1 to 0. It then captures addr, we and wdata into registers and enters WR_ADDR or RD_ADDR on the next edge.
REQ-015 Captured fields SHALL be used for the whole transaction. Requester input changes after grant SHALL be ignored.
REQ-016 WR_ADDR: awvalid and wvalid SHALL assert together. Each SHALL deassert independently after its own handshake. The FSM SHALL enter WR_RESP once both handshakes are complete, including when both complete in the same cycle.
REQ-017 WR_RESP: bready SHALL be 1. On bvalid the FSM SHALL capture bresp and enter DONE.
REQ-018 RD_ADDR: arvalid SHALL be 1 until arready, then the FSM SHALL enter RD_DATA.
REQ-019 RD_DATA: rready SHALL be 1. On rvalid the FSM SHALL capture rdata and rresp and enter DONE.
REQ-020 DONE: req_done[grant] SHALL pulse for exactly one cycle, last_grant SHALL update to grant, and the FSM SHALL return to IDLE.
REQ-021 Back-to-back operation: the earliest next grant SHALL occur in the IDLE cycle following DONE.
REQ-022 A requester that drops req_valid before it is granted SHALL simply not be granted. Dropping req_valid after grant SHALL NOT abort the transaction.
REQ-023 rsp_rdata SHALL hold its last captured value. It SHALL be 0 after a write completes.
REQ-024 At most one AXI transaction SHALL be outstanding at any time.
REQ-025 Minimum latency, grant to req_done, SHALL be 4 cycles when the slave is zero-wait.

Reset
REQ-026 On i_rst, all valid and ready outputs, req_done, busy, rsp_rdata and rsp_resp SHALL be 0, the FSM SHALL be IDLE, and last_grant SHALL be N_REQ-1, so that requester 0 has first priority.
REQ-027 A reset during a transaction SHALL abandon it without a req_done pulse. The AXI slave SHALL be reset on the same i_rst.

Configuration
REQ-028 Macro ARB_GRANT_CNT_EN: when defined, the block SHALL add output grant_cnt of width N_REQ*16. Each 16-bit counter SHALL increment once per req_done for its requester, saturate at 0xFFFF, and clear on i_rst.
REQ-029 When ARB_GRANT_CNT_EN is not defined, the port and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-030 Single write: req 0 writes 0xDEADBEEF to 0x10 with a zero-wait slave -> AW and W assert together, req_done[0] pulses 4 cycles after grant, rsp_resp = 0.
REQ-031 Single read: req 2 reads 0x20, slave returns 0x12345678 with 3 wait states on rvalid -> rsp_rdata = 0x12345678 with req_done[2], busy high throughout.
REQ-032 Fairness: all 4 requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3, and with ARB_GRANT_CNT_EN each grant_cnt = 2.
REQ-033 Split handshake: wready arrives 2 cycles after awready -> awvalid drops first, wvalid drops 2 cycles later, and exactly one B is accepted.
REQ-034 Error and reset: slave returns BRESP = 2 -> rsp_resp = 2. i_rst asserted in RD_DATA -> no req_done, all outputs 0, the next grant goes to requester 0.
